// File: rtl/ext_mem_block_bridge.sv
// Bridges the system memory port to a word-wide RAM, serialising single and block transfers.
// Build option: define EXT_BRIDGE_CRITICAL_WORD_FIRST_EN to start block reads at the requested word.
`timescale 1ns/1ps
module ext_mem_block_bridge #(
  parameter int BLOCK_WORDS = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        mem_req_i,
  input  logic        mem_reqBlock_i,
  input  logic        mem_clear_i,
  input  logic        mem_rw_i,
  input  logic [23:0] mem_add_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_done_o,
  output logic        mem_ready_o,
  output logic        mem_valid_o,
  output logic        ram_req_o,
  output logic        ram_rw_o,
  output logic [23:0] ram_add_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i,
  output logic [2:0]  dbg_state_o
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int CW = OW + 1;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, WR_FILL, WR_DRAIN, DONE} state_t;

  state_t           r_state;
  logic             r_block;
  logic [23-OW:0]   r_base_hi;
  logic [OW-1:0]    r_start;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_fill;
  logic [31:0]      r_buf [BLOCK_WORDS];

  logic [OW-1:0]    w_crit_off;
  logic [OW-1:0]    w_next_off;
  logic             w_last;
  logic             w_accept;

`ifdef EXT_BRIDGE_CRITICAL_WORD_FIRST_EN
  assign w_crit_off = mem_add_i[OW-1:0];
`else
  assign w_crit_off = '0;
`endif

  // Offsets wrap inside the block, so addresses never carry into the base bits.
  assign w_next_off  = r_start + r_cnt[OW-1:0] + OW'(1);
  assign w_last      = r_block ? (r_cnt == CW'(BLOCK_WORDS - 1)) : 1'b1;
  assign w_accept    = mem_req_i && mem_ready_o && !mem_clear_i && !reset_i;
  assign dbg_state_o = r_state;

  always_ff @(posedge clock_i) begin
    if (w_accept && mem_rw_i && mem_reqBlock_i)
      r_buf[0] <= mem_data_i;
    else if (r_state == WR_FILL && mem_req_i && !mem_clear_i && !reset_i)
      r_buf[r_fill[OW-1:0]] <= mem_data_i;
  end

  // RAM handshake: ram_req_o with ram_add_o/ram_rw_o/ram_data_o is held stable until a
  // cycle with ram_ack_i=1 completes the word; ack while ram_req_o=0 has no effect.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_block     <= 1'b0;
      r_base_hi   <= '0;
      r_start     <= '0;
      r_cnt       <= '0;
      r_fill      <= '0;
      mem_data_o  <= '0;
      mem_done_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_valid_o <= 1'b0;
      ram_req_o   <= 1'b0;
      ram_rw_o    <= 1'b0;
      ram_add_o   <= '0;
      ram_data_o  <= '0;
    end else if (mem_clear_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_fill      <= '0;
      mem_done_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_ready_o <= 1'b1;
      ram_req_o   <= 1'b0;
    end else begin
      mem_valid_o <= 1'b0;
      mem_done_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          mem_ready_o <= 1'b1;
          if (mem_req_i && mem_ready_o) begin
            mem_ready_o <= 1'b0;
            r_block     <= mem_reqBlock_i;
            r_base_hi   <= mem_add_i[23:OW];
            r_cnt       <= '0;
            r_fill      <= '0;
            ram_rw_o    <= mem_rw_i;
            r_start     <= (!mem_rw_i && mem_reqBlock_i) ? w_crit_off : '0;
            if (mem_rw_i && mem_reqBlock_i) begin
              r_fill  <= CW'(1);
              r_state <= WR_FILL;
            end else begin
              ram_req_o  <= 1'b1;
              ram_data_o <= mem_data_i;
              ram_add_o  <= mem_reqBlock_i ? {mem_add_i[23:OW], w_crit_off} : mem_add_i;
              r_state    <= mem_rw_i ? WR_DRAIN : RD_ISSUE;
            end
          end
        end
        WR_FILL: begin
          if (mem_req_i) begin
            r_fill <= r_fill + CW'(1);
            if (r_fill == CW'(BLOCK_WORDS - 1)) begin
              ram_req_o  <= 1'b1;
              ram_add_o  <= {r_base_hi, OW'(0)};
              ram_data_o <= r_buf[0];
              r_state    <= WR_DRAIN;
            end
          end
        end
        RD_ISSUE, WR_DRAIN: begin
          if (ram_req_o && ram_ack_i) begin
            if (r_state == RD_ISSUE) begin
              mem_data_o  <= ram_data_i;
              mem_valid_o <= 1'b1;
            end
            if (w_last) begin
              ram_req_o  <= 1'b0;
              mem_done_o <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cnt     <= r_cnt + CW'(1);
              ram_add_o <= {r_base_hi, w_next_off};
              if (r_state == WR_DRAIN) ram_data_o <= r_buf[w_next_off];
            end
          end
        end
        DONE: begin
          mem_ready_o <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_block_bridge.sv
// Bench for ext_mem_block_bridge: transaction-level model of expected RAM accesses and
// upstream responses, a randomly delayed RAM responder, directed cases and random traffic.
`timescale 1ns/1ps
module tb_ext_mem_block_bridge;
  localparam int BW = 16;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        mem_req_i, mem_reqBlock_i, mem_clear_i, mem_rw_i;
  logic [23:0] mem_add_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_done_o, mem_ready_o, mem_valid_o;
  logic        ram_req_o, ram_rw_o;
  logic [23:0] ram_add_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_ack_i;
  logic [2:0]  dbg_state_o;

  ext_mem_block_bridge #(.BLOCK_WORDS(BW)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .mem_req_i(mem_req_i), .mem_reqBlock_i(mem_reqBlock_i), .mem_clear_i(mem_clear_i),
    .mem_rw_i(mem_rw_i), .mem_add_i(mem_add_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_done_o(mem_done_o), .mem_ready_o(mem_ready_o),
    .mem_valid_o(mem_valid_o), .ram_req_o(ram_req_o), .ram_rw_o(ram_rw_o),
    .ram_add_o(ram_add_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_ack_i(ram_ack_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_i = ~clock_i;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [31:0] data;
    logic        last;
  } acc_t;

  acc_t        exp_q[$];
  logic [23:0] obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;
  int          n_done = 0;
  bit          mon_en = 0;
  bit          filling = 0;
  bit          in_txn = 0;
  logic        exp_valid = 0, exp_done = 0, exp_ready = 0;
  logic [31:0] exp_rdata = '0;
  bit          hold_prev = 0;
  logic [23:0] prev_add;
  logic        prev_rw;
  logic [31:0] prev_data;
  acc_t        e;

  int          fixed_lat = -1;
  bit          spur_en = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_fn(input logic [23:0] a);
    return {a[7:0], a} ^ 32'hA5A5_0000;
  endfunction

  function automatic void push_acc(input logic rw, input logic [23:0] a,
                                   input logic [31:0] d, input logic last);
    acc_t x;
    x.rw = rw; x.addr = a; x.data = d; x.last = last;
    exp_q.push_back(x);
  endfunction

  // ---------------- RAM responder ----------------
  initial begin : responder
    int  dly;
    bit  busy;
    dly = 0; busy = 0;
    ram_ack_i = 1'b0;
    ram_data_i = '0;
    forever begin
      @(posedge clock_i); #1;
      if (ram_req_o) begin
        if (!busy) begin
          busy = 1;
          dly = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (dly == 0) begin
          ram_ack_i  = 1'b1;
          ram_data_i = ovr_en ? ovr_val : ram_fn(ram_add_o);
          busy = 0;
        end else begin
          ram_ack_i  = 1'b0;
          ram_data_i = $urandom;
          dly--;
        end
      end else begin
        busy = 0;
        ram_ack_i  = spur_en && ($urandom_range(0, 9) == 0);
        ram_data_i = $urandom;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock_i) begin
    logic nv, nd, hs;
    logic [31:0] nrd;
    if (mon_en) begin
      chk("valid", mem_valid_o, exp_valid);
      if (exp_valid) chk("rdata", mem_data_o, exp_rdata);
      chk("done", mem_done_o, exp_done);
      chk("ready", mem_ready_o, exp_ready);
      chk("req_has_work", ram_req_o && (exp_q.size() == 0), 1'b0);
      if (filling) chk("fill_no_req", ram_req_o, 1'b0);
      if (hold_prev && ram_req_o) begin
        chk("hold_add", ram_add_o, prev_add);
        chk("hold_rw", ram_rw_o, prev_rw);
        chk("hold_data", ram_data_o, prev_data);
      end
      if (mem_valid_o) n_valid++;
      if (mem_done_o) n_done++;

      nv = 1'b0; nd = 1'b0; nrd = exp_rdata;
      hs = ram_req_o && ram_ack_i;
      if (reset_i || mem_clear_i) begin
        exp_q.delete();
        in_txn = 0;
      end else begin
        if (hs) begin
          obs_addr_q.push_back(ram_add_o);
          obs_data_q.push_back(ram_data_o);
          chk("access_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ram_rw", ram_rw_o, e.rw);
            chk("ram_add", ram_add_o, e.addr);
            if (e.rw) chk("ram_wdata", ram_data_o, e.data);
            else begin nv = 1'b1; nrd = e.data; end
            if (e.last) nd = 1'b1;
          end
        end
        if (exp_done) in_txn = 0;
        if (mem_req_i && exp_ready) in_txn = 1;
      end
      hold_prev = ram_req_o && !hs && !reset_i && !mem_clear_i;
      prev_add  = ram_add_o;
      prev_rw   = ram_rw_o;
      prev_data = ram_data_o;
      exp_ready = !reset_i && !in_txn;
      exp_valid = nv;
      exp_done  = nd;
      exp_rdata = nrd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_i); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!mem_ready_o && n < 400) begin tick(); n++; end
    chk("ready_timeout", mem_ready_o, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mem_ready_o && !in_txn) && n < 400) begin tick(); n++; end
    chk("idle_timeout", mem_ready_o, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic single_read(input logic [23:0] a);
    wait_ready();
    push_acc(1'b0, a, ovr_en ? ovr_val : ram_fn(a), 1'b1);
    mem_req_i = 1'b1; mem_reqBlock_i = 1'b0; mem_rw_i = 1'b0; mem_add_i = a;
    tick();
    mem_req_i = 1'b0;
  endtask

  task automatic single_write(input logic [23:0] a, input logic [31:0] d);
    wait_ready();
    push_acc(1'b1, a, d, 1'b1);
    mem_req_i = 1'b1; mem_reqBlock_i = 1'b0; mem_rw_i = 1'b1; mem_add_i = a; mem_data_i = d;
    tick();
    mem_req_i = 1'b0;
  endtask

  task automatic block_read(input logic [23:0] a);
    int st;
    logic [23:0] base, wa;
    st = 0;
`ifdef EXT_BRIDGE_CRITICAL_WORD_FIRST_EN
    st = int'(a % BW);
`endif
    base = a & ~24'(BW - 1);
    wait_ready();
    for (int i = 0; i < BW; i++) begin
      wa = base + 24'((st + i) % BW);
      push_acc(1'b0, wa, ram_fn(wa), i == BW - 1);
    end
    mem_req_i = 1'b1; mem_reqBlock_i = 1'b1; mem_rw_i = 1'b0; mem_add_i = a;
    tick();
    mem_req_i = 1'b0;
  endtask

  task automatic block_write(input logic [23:0] a, input logic [31:0] d0, input bit incr,
                             input int gap_at, input int gap_len);
    logic [31:0] d [BW];
    logic [23:0] base;
    base = a & ~24'(BW - 1);
    for (int i = 0; i < BW; i++) d[i] = incr ? d0 + 32'(i) : $urandom;
    wait_ready();
    for (int i = 0; i < BW; i++) push_acc(1'b1, base + 24'(i), d[i], i == BW - 1);
    mem_req_i = 1'b1; mem_reqBlock_i = 1'b1; mem_rw_i = 1'b1; mem_add_i = a; mem_data_i = d[0];
    tick();
    filling = 1;
    for (int i = 1; i < BW; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          mem_req_i = 1'b0; mem_data_i = $urandom;
          tick();
        end
      end
      mem_req_i = 1'b1; mem_data_i = d[i];
      tick();
    end
    mem_req_i = 1'b0;
    filling = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, d0, n;
    logic [23:0] ea;
    reset_i = 1'b1;
    mem_req_i = 1'b0; mem_reqBlock_i = 1'b0; mem_clear_i = 1'b0; mem_rw_i = 1'b0;
    mem_add_i = '0; mem_data_i = '0;
    @(posedge clock_i);
    mon_en = 1;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    chk("reset_ready_low", mem_ready_o, 1'b0);
    chk("reset_req_low", ram_req_o, 1'b0);
    tick();
    chk("post_reset_ready", mem_ready_o, 1'b1);

    // single read latency with immediate ack
    fixed_lat = 0;
    single_read(24'h000ABC);
    chk("lat_req", ram_req_o, 1'b1);
    chk("lat_add", ram_add_o, 24'h000ABC);
    tick();
    chk("lat_valid", mem_valid_o, 1'b1);
    chk("lat_done", mem_done_o, 1'b1);
    chk("lat_data", mem_data_o, 32'h2BBC_0ABC ^ 32'h0000_0000 ^ {8'hBC, 24'h000ABC} ^ 32'h2BBC_0ABC ^ 32'hA5A5_0000);
    wait_idle();

    // single read, ack two cycles after request
    fixed_lat = 2; ovr_en = 1; ovr_val = 32'hDEADBEEF;
    single_read(24'h000123);
    chk("r23_add", ram_add_o, 24'h000123);
    n = 0;
    while (!mem_valid_o && n < 10) begin tick(); n++; end
    chk("r23_latency", n, 3);
    chk("r23_data", mem_data_o, 32'hDEADBEEF);
    chk("r23_done", mem_done_o, 1'b1);
    wait_idle();
    ovr_en = 0;

    // block read, ack every cycle
    fixed_lat = 0;
    obs_addr_q.delete(); obs_data_q.delete();
    v0 = n_valid; d0 = n_done;
    block_read(24'h00004D);
    wait_idle();
    chk("r24_count", obs_addr_q.size(), BW);
    for (int i = 0; i < BW && i < obs_addr_q.size(); i++) begin
`ifdef EXT_BRIDGE_CRITICAL_WORD_FIRST_EN
      ea = (i < 3) ? 24'h4D + 24'(i) : 24'h40 + 24'(i - 3);
`else
      ea = 24'h40 + 24'(i);
`endif
      chk("r24_addr", obs_addr_q[i], ea);
    end
    chk("r24_valids", n_valid - v0, 16);
    chk("r24_dones", n_done - d0, 1);

    // block write with a two-cycle gap at word 5
    fixed_lat = 1;
    obs_addr_q.delete(); obs_data_q.delete();
    d0 = n_done;
    block_write(24'h000200, 32'h1000, 1'b1, 5, 2);
    wait_idle();
    chk("r25_count", obs_addr_q.size(), BW);
    for (int i = 0; i < BW && i < obs_addr_q.size(); i++) begin
      chk("r25_addr", obs_addr_q[i], 24'h200 + 24'(i));
      chk("r25_data", obs_data_q[i], 32'h1000 + 32'(i));
    end
    chk("r25_dones", n_done - d0, 1);

    // clear on the 8th ack of a block read
    fixed_lat = 0;
    v0 = n_valid; d0 = n_done;
    block_read(24'h000080);
    repeat (7) tick();
    mem_clear_i = 1'b1;
    tick();
    mem_clear_i = 1'b0;
    chk("r26_ready", mem_ready_o, 1'b1);
    chk("r26_req_off", ram_req_o, 1'b0);
    repeat (3) tick();
    chk("r26_valids", n_valid - v0, 7);
    chk("r26_dones", n_done - d0, 0);
    single_read(24'h000321);
    wait_idle();
    chk("r26_after_done", n_done - d0, 1);

    // clear and request together in idle
    wait_ready();
    mem_req_i = 1'b1; mem_clear_i = 1'b1; mem_reqBlock_i = 1'b0; mem_rw_i = 1'b0;
    tick();
    mem_req_i = 1'b0; mem_clear_i = 1'b0;
    chk("r18_no_req", ram_req_o, 1'b0);
    chk("r18_ready", mem_ready_o, 1'b1);

    // reset in the middle of a write drain
    fixed_lat = 1;
    block_write(24'h000300, 32'h0, 1'b0, 0, 0);
    repeat (3) tick();
    chk("r27_draining", ram_req_o, 1'b1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("r27_req", ram_req_o, 1'b0);
    chk("r27_rw", ram_rw_o, 1'b0);
    chk("r27_add", ram_add_o, 24'h0);
    chk("r27_wdata", ram_data_o, 32'h0);
    chk("r27_rdata", mem_data_o, 32'h0);
    chk("r27_valid", mem_valid_o, 1'b0);
    chk("r27_done", mem_done_o, 1'b0);
    chk("r27_ready0", mem_ready_o, 1'b0);
    tick();
    chk("r27_ready1", mem_ready_o, 1'b1);

    // random traffic
    fixed_lat = -1; spur_en = 1;
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [23:0] a;
      kind = $urandom_range(0, 3);
      a = 24'($urandom);
      case (kind)
        0: single_read(a);
        1: block_read(a);
        2: single_write(a, $urandom);
        default: block_write(a, 32'h0, 1'b0, $urandom_range(1, BW - 1), $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 8)) tick();
        mem_clear_i = 1'b1;
        tick();
        mem_clear_i = 1'b0;
      end
      wait_idle();
    end
    spur_en = 0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
